// File: rtl/postmortem_pkg.sv
// Shared definitions for the postmortem capture path: FSM state encodings,
// default geometry and channel index map used by the readout register map.
package postmortem_pkg;

  typedef enum logic [1:0] {
    PM_IDLE   = 2'd0,
    PM_ARMED  = 2'd1,
    PM_POST   = 2'd2,
    PM_FROZEN = 2'd3
  } pm_state_t;

  localparam int PM_CH_NUM     = 10;
  localparam int PM_DATA_WIDTH = 32;
  localparam int PM_RAM_DEPTH  = 4096;

  // Channel slots inside i_ch_data / o_ram_data, ch0 in the LSBs
  localparam int PM_CH_CURR    = 0;
  localparam int PM_CH_VOLT    = 1;
  localparam int PM_CH_DC_LINK = 2;
  localparam int PM_CH_IGBT_T0 = 3;
  localparam int PM_CH_IGBT_T1 = 4;
  localparam int PM_CH_IND_T0  = 5;
  localparam int PM_CH_IND_T1  = 6;
  localparam int PM_CH_RMS_R   = 7;
  localparam int PM_CH_RMS_S   = 8;
  localparam int PM_CH_RMS_T   = 9;

endpackage

// File: rtl/pm_wr_ptr.sv
// Circular write pointer for the postmortem RAMs. Counts modulo 2**ADDR_WIDTH
// and keeps a sticky flag once the pointer has rolled over from DEPTH-1 to 0.
module pm_wr_ptr #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  input  logic                  i_inc,
  output logic [ADDR_WIDTH-1:0] o_ptr,
  output logic                  o_wrapped
);

  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  r_wrapped;

  // Pointer and wrap flag; clear has priority over increment
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_ptr     <= '0;
      r_wrapped <= 1'b0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + 1'b1;
      if (&r_ptr) r_wrapped <= 1'b1;
    end
  end

  assign o_ptr     = r_ptr;
  assign o_wrapped = r_wrapped;

endmodule

// File: rtl/postmortem_capture_writer.sv
// Postmortem capture writer: streams channel samples into circular RAMs while
// armed, writes a programmed number of post-trigger samples after a fault and
// then freezes so software can unwind the buffer from o_w_ram_addr.
// Optional feature macro: PM_DECIM_EN (adds i_decim sample decimation).
module postmortem_capture_writer
  import postmortem_pkg::*;
#(
  parameter int CH_NUM     = PM_CH_NUM,
  parameter int DATA_WIDTH = PM_DATA_WIDTH,
  parameter int RAM_DEPTH  = PM_RAM_DEPTH,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_sample_valid,
  input  logic [CH_NUM*DATA_WIDTH-1:0] i_ch_data,
  input  logic                         i_arm,
  input  logic                         i_fault,
  input  logic                         i_clear,
  input  logic [ADDR_WIDTH-1:0]        i_post_cnt,
`ifdef PM_DECIM_EN
  input  logic [15:0]                  i_decim,
`endif
  output logic                         o_ram_we,
  output logic [ADDR_WIDTH-1:0]        o_ram_addr,
  output logic [CH_NUM*DATA_WIDTH-1:0] o_ram_data,
  output logic [31:0]                  o_w_ram_addr,
  output logic [31:0]                  o_trig_addr,
  output logic [1:0]                   o_state,
  output logic                         o_wrapped,
  output logic                         o_frozen
);

  pm_state_t                   r_state;
  logic                        r_we;
  logic [ADDR_WIDTH-1:0]       r_addr;
  logic [CH_NUM*DATA_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-1:0]       r_last_addr;
  logic [ADDR_WIDTH-1:0]       r_trig_addr;
  logic [ADDR_WIDTH-1:0]       r_post_cnt;

  logic                        w_write;
  logic                        w_trig;
  logic                        w_arm;
  logic                        w_dec_hit;
  logic [ADDR_WIDTH-1:0]       w_ptr;

`ifdef PM_DECIM_EN
  logic [15:0]                 r_dec_cnt;

  // Decimation counter: restarts on arm and after every written sample
  always_ff @(posedge i_clk) begin
    if (i_rst || w_arm) begin
      r_dec_cnt <= '0;
    end else if (i_sample_valid && !i_clear &&
                 (r_state == PM_ARMED || r_state == PM_POST)) begin
      if (w_write) r_dec_cnt <= '0;
      else         r_dec_cnt <= r_dec_cnt + 16'd1;
    end
  end

  assign w_dec_hit = (r_dec_cnt == i_decim);
`else
  assign w_dec_hit = 1'b1;
`endif

  assign w_arm = (r_state == PM_IDLE) && i_arm && !i_clear;

  // Write/trigger decision; clear suppresses anything pending this cycle
  always_comb begin
    w_write = 1'b0;
    w_trig  = 1'b0;
    if (!i_clear) begin
      case (r_state)
        PM_ARMED: begin
          w_trig  = i_fault;
          w_write = i_sample_valid && (i_fault || w_dec_hit);
        end
        PM_POST:  w_write = i_sample_valid && w_dec_hit;
        default:  ;
      endcase
    end
  end

  pm_wr_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (w_arm),
    .i_inc     (w_write),
    .o_ptr     (w_ptr),
    .o_wrapped (o_wrapped)
  );

  // Capture FSM with registered RAM write port, trigger address and post counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= PM_IDLE;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_last_addr <= '0;
      r_trig_addr <= '0;
      r_post_cnt  <= '0;
    end else begin
      r_we <= w_write;
      if (w_write) begin
        r_addr      <= w_ptr;
        r_data      <= i_ch_data;
        r_last_addr <= w_ptr;
      end
      if (i_clear) begin
        r_state <= PM_IDLE;
      end else begin
        case (r_state)
          PM_IDLE: begin
            if (i_arm) begin
              r_state     <= PM_ARMED;
              r_trig_addr <= '0;
            end
          end
          PM_ARMED: begin
            if (w_trig) begin
              // An ADDR_WIDTH-bit count is at most RAM_DEPTH-1, so the
              // trigger sample itself can never be overwritten.
              r_trig_addr <= w_ptr;
              r_post_cnt  <= i_post_cnt;
              r_state     <= (i_post_cnt == '0) ? PM_FROZEN : PM_POST;
            end
          end
          PM_POST: begin
            if (w_write) begin
              r_post_cnt <= r_post_cnt - 1'b1;
              if (r_post_cnt == ADDR_WIDTH'(1)) r_state <= PM_FROZEN;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_ram_we     = r_we;
  assign o_ram_addr   = r_addr;
  assign o_ram_data   = r_data;
  assign o_w_ram_addr = {{(32-ADDR_WIDTH){1'b0}}, r_last_addr};
  assign o_trig_addr  = {{(32-ADDR_WIDTH){1'b0}}, r_trig_addr};
  assign o_state      = r_state;
  assign o_frozen     = (r_state == PM_FROZEN);

endmodule

// File: tb/tb_postmortem_capture_writer.sv
// Directed bench for postmortem_capture_writer with a 16-deep buffer.
// Define PM_DECIM_EN to also exercise the decimation feature.
module tb_postmortem_capture_writer;

  localparam int CH  = 10;
  localparam int DW  = 32;
  localparam int DEP = 16;
  localparam int AW  = 4;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_sample_valid;
  logic [CH*DW-1:0] i_ch_data;
  logic            i_arm;
  logic            i_fault;
  logic            i_clear;
  logic [AW-1:0]   i_post_cnt;
`ifdef PM_DECIM_EN
  logic [15:0]     i_decim;
`endif
  logic            o_ram_we;
  logic [AW-1:0]   o_ram_addr;
  logic [CH*DW-1:0] o_ram_data;
  logic [31:0]     o_w_ram_addr;
  logic [31:0]     o_trig_addr;
  logic [1:0]      o_state;
  logic            o_wrapped;
  logic            o_frozen;

  int n_checks = 0;
  int n_fail   = 0;

  postmortem_capture_writer #(
    .CH_NUM(CH), .DATA_WIDTH(DW), .RAM_DEPTH(DEP), .ADDR_WIDTH(AW)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_sample_valid (i_sample_valid),
    .i_ch_data      (i_ch_data),
    .i_arm          (i_arm),
    .i_fault        (i_fault),
    .i_clear        (i_clear),
    .i_post_cnt     (i_post_cnt),
`ifdef PM_DECIM_EN
    .i_decim        (i_decim),
`endif
    .o_ram_we       (o_ram_we),
    .o_ram_addr     (o_ram_addr),
    .o_ram_data     (o_ram_data),
    .o_w_ram_addr   (o_w_ram_addr),
    .o_trig_addr    (o_trig_addr),
    .o_state        (o_state),
    .o_wrapped      (o_wrapped),
    .o_frozen       (o_frozen)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_sample(input logic [31:0] d, input logic f);
    i_sample_valid = 1'b1;
    i_fault        = f;
    i_ch_data      = '0;
    i_ch_data[31:0]         = d;
    i_ch_data[CH*DW-1 -: DW] = ~d;
    tick();
    i_sample_valid = 1'b0;
    i_fault        = 1'b0;
  endtask

  task automatic do_arm();
    i_arm = 1'b1;
    tick();
    i_arm = 1'b0;
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},    {31'd0, o_ram_we}, 32'd0);
    chk({tag, "_addr"},  {28'd0, o_ram_addr}, 32'd0);
    chk({tag, "_data0"}, o_ram_data[31:0], 32'd0);
    chk({tag, "_data9"}, o_ram_data[CH*DW-1 -: DW], 32'd0);
    chk({tag, "_wra"},   o_w_ram_addr, 32'd0);
    chk({tag, "_trig"},  o_trig_addr, 32'd0);
    chk({tag, "_state"}, {30'd0, o_state}, 32'd0);
    chk({tag, "_wrap"},  {31'd0, o_wrapped}, 32'd0);
    chk({tag, "_frz"},   {31'd0, o_frozen}, 32'd0);
  endtask

  initial begin
    i_rst = 1'b1; i_sample_valid = 1'b0; i_ch_data = '0; i_arm = 1'b0;
    i_fault = 1'b0; i_clear = 1'b0; i_post_cnt = '0;
`ifdef PM_DECIM_EN
    i_decim = 16'd0;
`endif
    repeat (2) @(posedge i_clk);
    #1;
    chk_all_zero("reset");
    i_rst = 1'b0;

    // 1: five samples after arm
    do_arm();
    chk("t1_state_armed", {30'd0, o_state}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      do_sample(32'h11 + i, 1'b0);
      chk("t1_we", {31'd0, o_ram_we}, 32'd1);
      chk("t1_addr", {28'd0, o_ram_addr}, i);
      chk("t1_data0", o_ram_data[31:0], 32'h11 + i);
      chk("t1_data9", o_ram_data[CH*DW-1 -: DW], ~(32'h11 + i));
    end
    tick();
    chk("t1_we_idle", {31'd0, o_ram_we}, 32'd0);
    chk("t1_wra", o_w_ram_addr, 32'd4);
    chk("t1_wrap", {31'd0, o_wrapped}, 32'd0);

    // 2: wrap, trigger at addr 3, three post samples, freeze
    do_clear();
    chk("t2_state_idle", {30'd0, o_state}, 32'd0);
    do_arm();
    i_post_cnt = 4'd3;
    for (int i = 1; i <= 20; i++) do_sample(32'h100 + i, (i == 20));
    chk("t2_trig_we", {31'd0, o_ram_we}, 32'd1);
    chk("t2_trig_wa", {28'd0, o_ram_addr}, 32'd3);
    chk("t2_trig_addr", o_trig_addr, 32'd3);
    chk("t2_state_post", {30'd0, o_state}, 32'd2);
    for (int k = 0; k < 3; k++) begin
      do_sample(32'h200 + k, 1'b0);
      chk("t2_post_addr", {28'd0, o_ram_addr}, 4 + k);
      chk("t2_post_state", {30'd0, o_state}, (k == 2) ? 32'd3 : 32'd2);
    end
    chk("t2_frozen", {31'd0, o_frozen}, 32'd1);
    do_sample(32'h999, 1'b1);
    chk("t2_frz_no_we", {31'd0, o_ram_we}, 32'd0);
    chk("t2_frz_wra", o_w_ram_addr, 32'd6);
    chk("t2_frz_trig", o_trig_addr, 32'd3);
    chk("t2_frz_wrap", {31'd0, o_wrapped}, 32'd1);
    do_arm();
    chk("t2_frz_arm_ign", {30'd0, o_state}, 32'd3);

    // 3a: zero post count -> frozen straight after trigger sample
    do_clear();
    do_arm();
    chk("t3_arm_wrap_clr", {31'd0, o_wrapped}, 32'd0);
    i_post_cnt = 4'd0;
    do_sample(32'hA0, 1'b1);
    chk("t3a_we", {31'd0, o_ram_we}, 32'd1);
    chk("t3a_addr", {28'd0, o_ram_addr}, 32'd0);
    chk("t3a_state", {30'd0, o_state}, 32'd3);
    chk("t3a_trig", o_trig_addr, 32'd0);
    do_sample(32'hA1, 1'b0);
    chk("t3a_no_we", {31'd0, o_ram_we}, 32'd0);

    // 3b: maximum post count of DEPTH-1 preserves the trigger sample
    do_clear();
    do_arm();
    i_post_cnt = 4'd15;
    do_sample(32'hB0, 1'b0);
    do_sample(32'hB1, 1'b0);
    do_sample(32'hB2, 1'b1);
    chk("t3b_trig", o_trig_addr, 32'd2);
    for (int k = 0; k < 15; k++) begin
      do_sample(32'hC0 + k, 1'b0);
      chk("t3b_addr", {28'd0, o_ram_addr}, (3 + k) % 16);
      chk("t3b_state", {30'd0, o_state}, (k == 14) ? 32'd3 : 32'd2);
    end
    chk("t3b_wra", o_w_ram_addr, 32'd1);
    chk("t3b_wrap", {31'd0, o_wrapped}, 32'd1);
    do_sample(32'hCF, 1'b0);
    chk("t3b_no_we", {31'd0, o_ram_we}, 32'd0);

    // 4: clear beats sample and fault in ARMED; fault in IDLE ignored
    do_clear();
    do_arm();
    i_clear = 1'b1;
    do_sample(32'hD0, 1'b1);
    i_clear = 1'b0;
    chk("t4_no_we", {31'd0, o_ram_we}, 32'd0);
    chk("t4_state", {30'd0, o_state}, 32'd0);
    do_sample(32'hD1, 1'b1);
    chk("t4_idle_fault", {30'd0, o_state}, 32'd0);
    chk("t4_idle_no_we", {31'd0, o_ram_we}, 32'd0);

    // 5: reset during POST
    do_arm();
    i_post_cnt = 4'd5;
    do_sample(32'hE0, 1'b1);
    do_sample(32'hE1, 1'b0);
    chk("t5_post", {30'd0, o_state}, 32'd2);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk_all_zero("t5_rst");
    do_arm();
    do_sample(32'hE2, 1'b0);
    chk("t5_rearm_we", {31'd0, o_ram_we}, 32'd1);
    chk("t5_rearm_addr", {28'd0, o_ram_addr}, 32'd0);

`ifdef PM_DECIM_EN
    // 6: decimation by 3, then trigger on a non-decimated sample
    do_clear();
    i_decim = 16'd2;
    do_arm();
    for (int i = 1; i <= 9; i++) begin
      do_sample(32'hF0 + i, 1'b0);
      chk("t6_we", {31'd0, o_ram_we}, (i % 3 == 0) ? 32'd1 : 32'd0);
      if (i % 3 == 0) begin
        chk("t6_addr", {28'd0, o_ram_addr}, i / 3 - 1);
        chk("t6_data", o_ram_data[31:0], 32'hF0 + i);
      end
    end
    do_clear();
    do_arm();
    i_post_cnt = 4'd2;
    for (int i = 1; i <= 3; i++) do_sample(32'h300 + i, 1'b0);
    do_sample(32'h304, 1'b1);
    chk("t6_trig_we", {31'd0, o_ram_we}, 32'd1);
    chk("t6_trig_wa", {28'd0, o_ram_addr}, 32'd1);
    chk("t6_trig_data", o_ram_data[31:0], 32'h304);
    chk("t6_trig_addr", o_trig_addr, 32'd1);
    chk("t6_state", {30'd0, o_state}, 32'd2);
    do_sample(32'h305, 1'b0);
    chk("t6_post_skip", {31'd0, o_ram_we}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
